// File: rtl/vga_sync_score_port_pkg.sv
// Shared constants for the catch-the-ball display front-end: default 1024x768 timing
// and the active-low 7-segment digit table.
package vga_sync_score_port_pkg;

    localparam int DEF_H_ACTIVE = 1024;
    localparam int DEF_H_FP     = 24;
    localparam int DEF_H_SYNC   = 136;
    localparam int DEF_H_BP     = 160;
    localparam int DEF_V_ACTIVE = 768;
    localparam int DEF_V_FP     = 3;
    localparam int DEF_V_SYNC   = 6;
    localparam int DEF_V_BP     = 29;
    localparam int DEF_SYNC_POL = 0;

    localparam int DEF_H_TOTAL      = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL      = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;
    localparam int DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

    // bit6..bit0 = g f e d c b a, active-low; entry [0] is the digit 0
    localparam logic [9:0][6:0] SEG_TBL = {
        7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
        7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    function automatic logic [6:0] seg7(input logic [31:0] d);
        if (d < 32'd10)
            return SEG_TBL[d[3:0]];
        else
            return 7'h7F;
    endfunction

endpackage

// File: rtl/vga_sync_score_port_score_hex_pair.sv
// Two-digit decimal readout of a 32-bit counter; values of 100 and up show mod 100.
module score_hex_pair
    import vga_sync_score_port_pkg::*;
(
    input  logic [31:0] value,
    output logic [6:0]  ones,
    output logic [6:0]  tens
);

    logic [31:0] rem100;
    logic [31:0] ones_d;
    logic [31:0] tens_d;

    assign rem100 = value % 32'd100;
    assign ones_d = rem100 % 32'd10;
    assign tens_d = rem100 / 32'd10;

    assign ones = seg7(ones_d);
    assign tens = seg7(tens_d);

endmodule

// File: rtl/vga_sync_score_port.sv
// VGA timing generator plus three 2-digit score readouts for the board HEX displays.
// Sync/blank are registered one clk behind vga_x/vga_y to line up with the colour path.
module vga_sync_score_port
    import vga_sync_score_port_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int SYNC_POL = DEF_SYNC_POL
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] vga_x,
    output logic [31:0] vga_y,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank,
    output logic        vga_clk,
    input  logic [31:0] missed,
    input  logic [31:0] score,
    input  logic [31:0] best,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5
);

    localparam logic [31:0] H_TOTAL  = 32'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [31:0] V_TOTAL  = 32'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam logic [31:0] H_VIS    = 32'(H_ACTIVE);
    localparam logic [31:0] V_VIS    = 32'(V_ACTIVE);
    localparam logic [31:0] HS_START = 32'(H_ACTIVE + H_FP);
    localparam logic [31:0] HS_END   = 32'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [31:0] VS_START = 32'(V_ACTIVE + V_FP);
    localparam logic [31:0] VS_END   = 32'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic        SYNC_ACT = (SYNC_POL != 0);

    logic [31:0] h;
    logic [31:0] v;
    logic        in_hsync;
    logic        in_vsync;
    logic        visible;

    assign in_hsync = (h >= HS_START) && (h <= HS_END);
    assign in_vsync = (v >= VS_START) && (v <= VS_END);
    assign visible  = (h < H_VIS) && (v < V_VIS);

    always_ff @(posedge clk) begin
        if (!reset) begin
            h         <= '0;
            v         <= '0;
            vga_hs    <= ~SYNC_ACT;
            vga_vs    <= ~SYNC_ACT;
            vga_blank <= 1'b0;
        end else begin
            if (h == H_TOTAL - 1) begin
                h <= '0;
                v <= (v == V_TOTAL - 1) ? '0 : v + 32'd1;
            end else begin
                h <= h + 32'd1;
            end
            vga_hs    <= in_hsync ? SYNC_ACT : ~SYNC_ACT;
            vga_vs    <= in_vsync ? SYNC_ACT : ~SYNC_ACT;
            vga_blank <= visible;
        end
    end

    assign vga_x   = h;
    assign vga_y   = v;
    assign vga_clk = ~clk;

    score_hex_pair u_missed (.value(missed), .ones(hex0), .tens(hex1));
    score_hex_pair u_score  (.value(score),  .ones(hex2), .tens(hex3));
    score_hex_pair u_best   (.value(best),   .ones(hex4), .tens(hex5));

endmodule

// File: tb/tb_vga_sync_score_port.sv
// Bench for vga_sync_score_port: full-width lines, a short frame (fewer active lines)
// so a whole frame fits in a brief run, and a randomized score-decode sweep.
module tb_vga_sync_score_port;

    localparam int HA = 1024, HF = 24, HS = 136, HB = 160;
    localparam int VA = 20,   VF = 3,  VS = 6,   VB = 5;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] missed = '0, score = '0, best = '0;
    logic [31:0] vga_x, vga_y;
    logic        vga_hs, vga_vs, vga_blank, vga_clk;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_ref [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    vga_sync_score_port #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(0)
    ) dut (
        .clk(clk), .reset(reset),
        .vga_x(vga_x), .vga_y(vga_y), .vga_hs(vga_hs), .vga_vs(vga_vs),
        .vga_blank(vga_blank), .vga_clk(vga_clk),
        .missed(missed), .score(score), .best(best),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // t = number of running clk edges since the counters were last cleared
    task automatic check_timing(input int t);
        int  hp, vp;
        logic ehs, evs, ebl;
        if (t == 0) begin
            ehs = 1'b1; evs = 1'b1; ebl = 1'b0;
        end else begin
            hp  = (t - 1) % HT;
            vp  = ((t - 1) / HT) % VT;
            ehs = !(hp >= HA + HF && hp < HA + HF + HS);
            evs = !(vp >= VA + VF && vp < VA + VF + VS);
            ebl = (hp < HA) && (vp < VA);
        end
        check("vga_x", vga_x, 32'(t % HT));
        check("vga_y", vga_y, 32'((t / HT) % VT));
        check("vga_hs", {31'b0, vga_hs}, {31'b0, ehs});
        check("vga_vs", {31'b0, vga_vs}, {31'b0, evs});
        check("vga_blank", {31'b0, vga_blank}, {31'b0, ebl});
    endtask

    task automatic check_pair(input string tag, input logic [6:0] ones, input logic [6:0] tens,
                              input logic [31:0] val);
        check({tag, "_ones"}, {25'b0, ones}, {25'b0, seg_ref[int'(val % 32'd10)]});
        check({tag, "_tens"}, {25'b0, tens}, {25'b0, seg_ref[int'((val / 32'd10) % 32'd10)]});
    endtask

    initial begin
        int tcur;
        int hs_low, blank_hi, vs_low;
        logic [31:0] dir_val [4] = '{32'd0, 32'd7, 32'd42, 32'd99};
        logic [6:0]  dir_ten [4] = '{7'b1000000, 7'b1000000, 7'b0011001, 7'b0010000};
        logic [6:0]  dir_one [4] = '{7'b1000000, 7'b1111000, 7'b0100100, 7'b0010000};

        // reset held for three edges
        repeat (3) step();
        check_timing(0);
        check("vga_clk", {31'b0, vga_clk}, 32'd0);
        reset = 1'b1;

        tcur = 0; hs_low = 0; blank_hi = 0; vs_low = 0;
        for (int i = 0; i < HT * VT + 1; i++) begin
            step();
            tcur++;
            check_timing(tcur);
            if (tcur <= HT) begin
                if (!vga_hs) hs_low++;
                if (vga_blank) blank_hi++;
            end
            if (tcur <= HT * VT && !vga_vs) vs_low++;
            if (tcur == HT * VT) begin
                check("frame_wrap_x", vga_x, 32'd0);
                check("frame_wrap_y", vga_y, 32'd0);
            end
        end
        check("hs_low_count", 32'(hs_low), 32'(HS));
        check("blank_hi_count", 32'(blank_hi), 32'(HA));
        check("vs_low_count", 32'(vs_low), 32'(VS * HT));
        check("vga_clk_hi", {31'b0, vga_clk}, 32'd0);

        // run on to x=500, y=10, then a single-edge reset
        for (int i = 0; i < HT * VT; i++) begin
            if ((tcur % HT) == 500 && ((tcur / HT) % VT) == 10) break;
            step();
            tcur++;
            check_timing(tcur);
        end
        check("mid_x_reached", vga_x, 32'd500);
        check("mid_y_reached", vga_y, 32'd10);
        reset = 1'b0;
        step();
        check_timing(0);
        reset = 1'b1;
        tcur = 0;
        for (int i = 0; i < 2 * HT + 10; i++) begin
            step();
            tcur++;
            check_timing(tcur);
        end

        // directed decode sweep on score
        for (int i = 0; i < 4; i++) begin
            score = dir_val[i];
            #1;
            check("dir_hex3", {25'b0, hex3}, {25'b0, dir_ten[i]});
            check("dir_hex2", {25'b0, hex2}, {25'b0, dir_one[i]});
        end

        // wrap and independence
        missed = 32'd11; score = 32'd123; best = 32'hFFFF_FFFF;
        #1;
        check("wrap_hex1", {25'b0, hex1}, {25'b0, 7'b1111001});
        check("wrap_hex0", {25'b0, hex0}, {25'b0, 7'b1111001});
        check("wrap_hex3", {25'b0, hex3}, {25'b0, 7'b0100100});
        check("wrap_hex2", {25'b0, hex2}, {25'b0, 7'b0110000});
        check("wrap_hex5", {25'b0, hex5}, {25'b0, 7'b0010000});
        check("wrap_hex4", {25'b0, hex4}, {25'b0, 7'b0010010});
        score = 32'd58;
        #1;
        check_pair("indep_score", hex2, hex3, 32'd58);
        check_pair("indep_missed", hex0, hex1, 32'd11);
        check_pair("indep_best", hex4, hex5, 32'hFFFF_FFFF);

        // randomized decode against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            missed = $urandom;
            score  = (i % 2 == 0) ? $urandom_range(0, 199) : $urandom;
            best   = $urandom;
            #1;
            check_pair("rnd_missed", hex0, hex1, missed);
            check_pair("rnd_score", hex2, hex3, score);
            check_pair("rnd_best", hex4, hex5, best);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_sync_score_port.md
Name: vga_sync_score_port

Overview:
- Display front-end for the catch-the-ball game.
- Generates 1024x768 VGA timing: pixel coordinates, sync, blank and DAC clock.
- Converts three 32-bit game counters (missed balls, current score, highest score) into two-digit decimal active-low 7-segment patterns for HEX0..HEX5.
- Sits between the game logic, the video DAC and the board displays; the game logic computes RGB from vga_x/vga_y and registers it one clk later.

Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch (pixels)
- H_SYNC, 136, horizontal sync width
- H_BP, 160, horizontal back porch
- V_ACTIVE, 768, visible lines
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vertical sync width
- V_BP, 29, vertical back porch
- SYNC_POL, 0, active level of hs/vs (0 = negative sync)

Ports:
- clk  in  1  pixel clock, 65 MHz nominal
- reset  in  1  synchronous, active-low
- vga_x  out  32  current horizontal count, 0..H_TOTAL-1
- vga_y  out  32  current vertical count, 0..V_TOTAL-1
- vga_hs  out  1  horizontal sync
- vga_vs  out  1  vertical sync
- vga_blank  out  1  DAC BLANK_N; 1 = visible pixel
- vga_clk  out  1  DAC clock, equal to ~clk
- missed  in  32  missed-ball count
- score  in  32  current score
- best  in  32  highest score
- hex0/hex1  out  7 each  missed, ones/tens digit
- hex2/hex3  out  7 each  score, ones/tens digit
- hex4/hex5  out  7 each  best, ones/tens digit

Behaviour:
- Totals: H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP = 1344; V_TOTAL = 806.
- Reset is synchronous, active-low, clock clk. While reset=0 at a clk edge:
  - h and v counters go to 0;
  - vga_hs and vga_vs go to the inactive level (1 for negative polarity);
  - vga_blank goes to 0.
- Counting: h increments every clk. At H_TOTAL-1 it wraps to 0 and v increments. When v is at V_TOTAL-1 and h wraps, v wraps to 0.
- vga_x = h and vga_y = v, taken directly from the counter registers (no extra delay).
- Line layout, in h order:
  - active region: h = 0..H_ACTIVE-1;
  - front porch;
  - sync region: h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 1048..1183;
  - back porch.
- Frame layout uses the same order with v. The vertical sync region is v in 771..776.
- Sync and blank are registered: they reflect the h/v value of the previous clk. This matches the game's one-cycle registered colour path.
  - vga_hs is at the active level when the previous h was in the sync region.
  - vga_vs is at the active level when the previous v was in the sync region.
  - vga_blank = 1 when the previous (h < H_ACTIVE && v < V_ACTIVE).
- vga_vs changes only on the clk edge after h wraps to 0.
- vga_clk = ~clk, so the DAC samples mid-pixel. It is combinational and unaffected by reset.
- Score decode is purely combinational, with zero latency:
  - ones digit = value mod 10; tens digit = (value / 10) mod 10;
  - values of 100 or more wrap, e.g. 123 shows "23";
  - the tens digit shows '0' and is not blanked, e.g. 5 shows "05".
- 7-segment encoding is active-low, bit6..bit0 = g f e d c b a:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
- Inputs are unsigned; all 32 bits are used in the mod-100 reduction.

Decomposition:
- Shared package holds:
  - timing constants and derived totals and sync-window bounds;
  - the 10-entry 7-segment digit table.
- One natural sub-module, score_hex_pair: 32-bit in, two 7-bit digit outputs. It is instantiated three times (missed, score, best).
- Timing counters stay in the top module.

Test Plan:
- Reset: hold reset=0 for 3 clk, then release.
  - Required at release: vga_x=0, vga_y=0, vga_hs=1, vga_vs=1, vga_blank=0.
  - On the first clk after release: vga_blank=1.
- Line timing: count clk edges over one line.
  - vga_x goes 0..1343 and then wraps to 0, with vga_y incrementing at the wrap.
  - vga_hs is low for exactly 136 clk, starting one clk after vga_x=1048.
  - vga_blank is high for exactly 1024 clk per active line.
- Frame timing: run 1344*806 clk.
  - vga_vs is low for 6*1344 clk, starting one clk after vga_y=771, vga_x=0.
  - vga_blank stays 0 throughout lines 768..805.
  - The counter returns to (0,0) after exactly 1083264 clk.
- Decode sweep, with score driven to each value:
  - 0 -> hex3=1000000, hex2=1000000
  - 7 -> hex3=1000000, hex2=1111000
  - 42 -> hex3=0011001, hex2=0100100
  - 99 -> both digits 0010000
- Wrap and independence: drive missed=11, score=123, best=4294967295.
  - missed -> hex1/hex0 show "11".
  - score -> hex3/hex2 show "23".
  - best -> hex5/hex4 show "95".
  - Each pair changes in the same cycle its input changes.
- Mid-frame reset: assert reset=0 at vga_x=500, vga_y=300 for 1 clk.
  - Next clk: counters are 0, hs/vs are inactive, vga_blank=0.
  - Timing then restarts cleanly from (0,0).
